pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline.
- Drives the enable of the F/D pipeline registers and the flush (bubble insert) of the D/E register.
- Detects register RAW hazards between the D stage and the E/M stages using Tuse/Tnew.
- Sequences the multi-cycle mult/div unit with a busy FSM; the E/M and M/W registers stay enabled.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (2..15).
- DIV_CYCLES, 10, busy cycles after a div/divu start (2..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- D_rs_addr  in  5  rs of the instruction in D.
- D_rt_addr  in  5  rt of the instruction in D.
- D_rs_tuse  in  2  cycles until D needs rs; 3 = rs unused.
- D_rt_tuse  in  2  cycles until D needs rt; 3 = rt unused.
- D_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_wa  in  5  destination register of the E instruction; 0 = none.
- E_tnew  in  2  cycles until E result is forwardable.
- M_wa  in  5  destination register of the M instruction.
- M_tnew  in  2  cycles until M result is forwardable.
- E_md_start  in  1  mult/div in E this cycle; one-cycle pulse.
- E_md_div  in  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu.
- F_en  out  1  PC/F-D register enable.
- D_en  out  1  D-E input-side enable (PC and F/D hold).
- E_flush  out  1  synchronous clear of the D/E register.
- md_busy  out  1  mult/div unit busy.
- md_err  out  1  sticky: E_md_start while busy.
- stall_cnt  out  16  saturating count of stall cycles.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM = IDLE, counter = 0, md_busy = 0, md_err = 0, stall_cnt = 0.
  - Combinational outputs follow the inputs: F_en = D_en = 1 and E_flush = 0 unless a stall condition holds.
- RAW stall, combinational:
  - stall_rs = (D_rs_addr != 0) && ((D_rs_addr == E_wa && D_rs_tuse < E_tnew) || (D_rs_addr == M_wa && D_rs_tuse < M_tnew)).
  - stall_rt is the same with rt.
  - Tuse = 3 never stalls, because Tnew is at most 2 in practice and 3 < 3 is false.
- MD stall: stall_md = D_md_use && (md_busy || E_md_start).
  - This covers back-to-back mult/div and mfhi directly after a mult.
- stall = stall_rs | stall_rt | stall_md.
  - F_en = D_en = ~stall; E_flush = stall.
  - All three take effect in the same cycle, with no register in the path.
- MD FSM, states IDLE and BUSY:
  - IDLE, E_md_start = 1: load cnt = E_md_div ? DIV_CYCLES : MULT_CYCLES, go to BUSY.
  - BUSY: cnt decrements each cycle. When cnt == 1, go to IDLE on the next edge and set cnt = 0.
  - md_busy = (state == BUSY). A start seen at edge t gives md_busy high for exactly N cycles after that edge.
  - BUSY with E_md_start = 1: the start is ignored, counting continues, and md_err is set. md_err clears only on reset.
  - A mid-operation reset returns the FSM to IDLE immediately and clears md_busy.
- stall_cnt:
  - Increments on each rising edge where stall = 1.
  - Holds at 16'hFFFF and does not wrap.
- No other state is held. Forwarding-mux selection is outside this block.

Test Plan:
- Load-use: E_wa=8, E_tnew=2, D_rs_addr=8, D_rs_tuse=1 -> F_en=0, D_en=0, E_flush=1. Next cycle, with E_tnew advanced via M_tnew=1 and M_wa=8 -> F_en=1.
- $0 and unused operands: D_rs_addr=0 matching E_wa=0 with E_tnew=2, and D_rt_tuse=3 matching E_wa -> no stall.
- mult then mfhi: E_md_start=1, E_md_div=0, D_md_use=1 -> stall that cycle. md_busy high exactly 5 cycles and stall held throughout. First mfhi issue comes on the cycle md_busy falls.
- div with DIV_CYCLES=10 -> md_busy high for 10 consecutive cycles. During this, unrelated D instructions (D_md_use=0, no RAW) -> F_en=1.
- E_md_start pulsed during BUSY -> md_err=1, busy duration unchanged. Assert reset mid-BUSY -> md_busy=0, md_err=0 asynchronously.
- Force stall=1 for 70000 cycles -> stall_cnt = 16'hFFFF, no wrap. Reset -> stall_cnt = 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: RAW hazard detection via Tuse/Tnew plus a
// busy sequencer for the multi-cycle mult/div unit and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_md_use,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        F_en,
  output logic        D_en,
  output logic        E_flush,
  output logic        md_busy,
  output logic        md_err,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE,
    BUSY
  } md_state_t;

  md_state_t  md_state;
  logic [3:0] md_cnt;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;
  logic       stall;

  // An operand stalls only if a producer still needs more cycles than D can wait.
  always_comb begin
    stall_rs = (D_rs_addr != 5'd0) &&
               (((D_rs_addr == E_wa) && (D_rs_tuse < E_tnew)) ||
                ((D_rs_addr == M_wa) && (D_rs_tuse < M_tnew)));
    stall_rt = (D_rt_addr != 5'd0) &&
               (((D_rt_addr == E_wa) && (D_rt_tuse < E_tnew)) ||
                ((D_rt_addr == M_wa) && (D_rt_tuse < M_tnew)));
    stall_md = D_md_use && (md_busy || E_md_start);
    stall    = stall_rs || stall_rt || stall_md;
  end

  assign F_en    = ~stall;
  assign D_en    = ~stall;
  assign E_flush = stall;
  assign md_busy = (md_state == BUSY);

  // Starts arriving while busy are dropped and flagged rather than restarting the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_state <= IDLE;
      md_cnt   <= 4'd0;
      md_err   <= 1'b0;
    end else begin
      case (md_state)
        IDLE: begin
          if (E_md_start) begin
            md_cnt   <= E_md_div ? DIV_LOAD : MULT_LOAD;
            md_state <= BUSY;
          end
        end
        BUSY: begin
          if (E_md_start) md_err <= 1'b1;
          if (md_cnt == 4'd1) begin
            md_cnt   <= 4'd0;
            md_state <= IDLE;
          end else begin
            md_cnt <= md_cnt - 4'd1;
          end
        end
        default: begin
          md_state <= IDLE;
          md_cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a cycle-count model of the controller.
module tb_pipe_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  D_rs_addr = '0, D_rt_addr = '0, E_wa = '0, M_wa = '0;
  logic [1:0]  D_rs_tuse = 2'd3, D_rt_tuse = 2'd3, E_tnew = '0, M_tnew = '0;
  logic        D_md_use = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
  logic        F_en, D_en, E_flush, md_busy, md_err;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b1;

  int m_remaining = 0;
  bit m_err = 1'b0;
  int m_stalls = 0;

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_md_use(D_md_use),
    .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .F_en(F_en), .D_en(D_en), .E_flush(E_flush),
    .md_busy(md_busy), .md_err(md_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit operand_waits(input logic [4:0] a, input logic [1:0] tuse);
    bit w;
    w = 1'b0;
    if (a != 0) begin
      if (a == E_wa && int'(tuse) < int'(E_tnew)) w = 1'b1;
      if (a == M_wa && int'(tuse) < int'(M_tnew)) w = 1'b1;
    end
    return w;
  endfunction

  function automatic bit model_stall();
    return operand_waits(D_rs_addr, D_rs_tuse) || operand_waits(D_rt_addr, D_rt_tuse) ||
           (D_md_use && (m_remaining > 0 || E_md_start));
  endfunction

  // Reference: remaining busy cycles as a plain integer, stall total clamped at 65535.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_remaining <= 0;
      m_err       <= 1'b0;
      m_stalls    <= 0;
    end else begin
      if (m_remaining == 0) begin
        if (E_md_start) m_remaining <= E_md_div ? DIV_N : MULT_N;
      end else begin
        m_remaining <= m_remaining - 1;
        if (E_md_start) m_err <= 1'b1;
      end
      if (model_stall()) m_stalls <= (m_stalls >= 65535) ? 65535 : m_stalls + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("F_en",      32'(F_en),      32'(!model_stall()));
      checkOutput("D_en",      32'(D_en),      32'(!model_stall()));
      checkOutput("E_flush",   32'(E_flush),   32'(model_stall()));
      checkOutput("md_busy",   32'(md_busy),   32'(m_remaining > 0));
      checkOutput("md_err",    32'(md_err),    32'(m_err));
      checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    D_rs_addr = 0; D_rt_addr = 0; D_rs_tuse = 3; D_rt_tuse = 3; D_md_use = 0;
    E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0; E_md_start = 0; E_md_div = 0;
  endtask

  task automatic applyStimulus();
    D_rs_addr  = 5'($urandom_range(0, 3));
    D_rt_addr  = 5'($urandom_range(0, 3));
    D_rs_tuse  = 2'($urandom_range(0, 3));
    D_rt_tuse  = 2'($urandom_range(0, 3));
    E_wa       = 5'($urandom_range(0, 3));
    M_wa       = 5'($urandom_range(0, 3));
    E_tnew     = 2'($urandom_range(0, 2));
    M_tnew     = 2'($urandom_range(0, 2));
    D_md_use   = ($urandom_range(0, 2) == 0);
    E_md_start = ($urandom_range(0, 5) == 0);
    E_md_div   = $urandom_range(0, 1) == 1;
  endtask

  int n;

  initial begin
    clearInputs();
    #12;
    checkOutput("rst_md_busy", 32'(md_busy), 32'd0);
    checkOutput("rst_md_err", 32'(md_err), 32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst_F_en", 32'(F_en), 32'd1);
    step();
    reset = 1'b1;
    step();

    // Load-use on rs
    E_wa = 8; E_tnew = 2; D_rs_addr = 8; D_rs_tuse = 1;
    #1;
    checkOutput("lu_F_en", 32'(F_en), 32'd0);
    checkOutput("lu_D_en", 32'(D_en), 32'd0);
    checkOutput("lu_E_flush", 32'(E_flush), 32'd1);
    step();
    E_wa = 0; E_tnew = 0; M_wa = 8; M_tnew = 1;
    #1;
    checkOutput("lu_resolved_F_en", 32'(F_en), 32'd1);
    step();

    // $0 and unused operand never stall
    clearInputs();
    D_rs_addr = 0; E_wa = 0; E_tnew = 2; D_rs_tuse = 0;
    #1;
    checkOutput("zero_reg_F_en", 32'(F_en), 32'd1);
    step();
    clearInputs();
    D_rt_addr = 9; D_rt_tuse = 3; E_wa = 9; E_tnew = 2;
    #1;
    checkOutput("unused_rt_F_en", 32'(F_en), 32'd1);
    step();

    // mult followed by mfhi
    clearInputs();
    E_md_start = 1; E_md_div = 0; D_md_use = 1;
    #1;
    checkOutput("mult_start_flush", 32'(E_flush), 32'd1);
    step();
    E_md_start = 0;
    n = 0;
    while (md_busy && n < 40) begin
      checkOutput("mult_hold_F_en", 32'(F_en), 32'd0);
      n++;
      step();
    end
    checkOutput("mult_busy_cycles", 32'(n), 32'(MULT_N));
    checkOutput("mfhi_issue_F_en", 32'(F_en), 32'd1);

    // div with unrelated traffic flowing
    clearInputs();
    E_md_start = 1; E_md_div = 1;
    step();
    E_md_start = 0; D_rs_addr = 4; D_rs_tuse = 0;
    n = 0;
    while (md_busy && n < 40) begin
      checkOutput("div_unrelated_F_en", 32'(F_en), 32'd1);
      n++;
      step();
    end
    checkOutput("div_busy_cycles", 32'(n), 32'(DIV_N));

    // Start during busy flags an error without stretching the operation
    clearInputs();
    E_md_start = 1;
    step();
    n = 1;
    step();
    n++;
    E_md_start = 0;
    while (md_busy && n < 40) begin
      n++;
      step();
    end
    checkOutput("err_busy_cycles", 32'(n - 1), 32'(MULT_N));
    checkOutput("err_sticky", 32'(md_err), 32'd1);
    E_md_start = 1;
    step();
    E_md_start = 0;
    step();
    checkOutput("mid_busy_pre", 32'(md_busy), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("async_rst_busy", 32'(md_busy), 32'd0);
    checkOutput("async_rst_err", 32'(md_err), 32'd0);
    step();
    reset = 1'b1;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      reset = ($urandom_range(0, 499) != 0);
      step();
    end
    reset = 1'b1;
    clearInputs();
    step();

    // Long forced stall must saturate, not wrap
    check_en = 1'b0;
    E_wa = 8; E_tnew = 2; D_rs_addr = 8; D_rs_tuse = 0;
    for (int i = 0; i < 70000; i++) step();
    check_en = 1'b1;
    step();
    step();
    checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
    reset = 1'b0;
    #1;
    checkOutput("rst_after_sat", 32'(stall_cnt), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
